mem_writeback_stage: RTL and testbench

- Final pipeline stage between the memory stage and the 32x32 register file.
- Buffers one retiring instruction and waits for variable-latency load data when needed.
- Extracts and extends byte/halfword loads, then drives the register-file write port (RegWrite, Write_register, Write_data) from registers.
- Also exports forwarding and load-pending hazard information to the decode stage.

---
 rtl/mem_writeback_stage_if.sv | 34 +++
 rtl/mem_writeback_stage.sv | 144 ++++++++++++++
 tb/tb_mem_writeback_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_writeback_stage_if.sv
// Upstream retire bus, memory read-return and register-file write port of the
// writeback stage, grouped so the stage and its surroundings share one bundle.
interface mem_writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_write_register;
  logic [31:0] in_alu_result;
  logic        in_is_load;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        load_pending;
  logic [4:0]  load_register;
  logic        load_timeout;

  modport slave (
    input  in_valid, in_reg_write, in_write_register, in_alu_result,
           in_is_load, in_load_size, in_load_signed, mem_rdata_valid, mem_rdata,
    output in_ready, RegWrite, Write_register, Write_data,
           load_pending, load_register, load_timeout
  );

  modport master (
    output in_valid, in_reg_write, in_write_register, in_alu_result,
           in_is_load, in_load_size, in_load_signed, mem_rdata_valid, mem_rdata,
    input  in_ready, RegWrite, Write_register, Write_data,
           load_pending, load_register, load_timeout
  );
endinterface

// File: rtl/mem_writeback_stage.sv
// Writeback stage: retires one instruction at a time, waits for load data with a
// timeout, extracts byte/half/word loads and drives the register-file write port.
module mem_writeback_stage #(
  parameter int LOAD_TIMEOUT = 255,
  parameter int TIMEOUT_W    = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  mem_writeback_stage_if.slave wb
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 ld_we_q, ld_we_d;
  logic [4:0]           ld_reg_q, ld_reg_d;
  logic [1:0]           ld_size_q, ld_size_d;
  logic                 ld_signed_q, ld_signed_d;
  logic [1:0]           ld_off_q, ld_off_d;
  logic                 reg_write_q, reg_write_d;
  logic [4:0]           write_register_q, write_register_d;
  logic [31:0]          write_data_q, write_data_d;
  logic                 load_pending_q, load_pending_d;
  logic [4:0]           load_register_q, load_register_d;
  logic                 load_timeout_q, load_timeout_d;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          load_data;

  // Little-endian lane select on the aligned word, then sign/zero extension.
  always_comb begin
    ld_byte = 8'h00;
    case (ld_off_q)
      2'd0:    ld_byte = wb.mem_rdata[7:0];
      2'd1:    ld_byte = wb.mem_rdata[15:8];
      2'd2:    ld_byte = wb.mem_rdata[23:16];
      default: ld_byte = wb.mem_rdata[31:24];
    endcase
    ld_half = ld_off_q[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
    case (ld_size_q)
      2'b00:   load_data = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{ld_signed_q & ld_half[15]}}, ld_half};
      default: load_data = wb.mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ld_we_d          = ld_we_q;
    ld_reg_d         = ld_reg_q;
    ld_size_d        = ld_size_q;
    ld_signed_d      = ld_signed_q;
    ld_off_d         = ld_off_q;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    load_pending_d   = load_pending_q;
    load_register_d  = load_register_q;
    load_timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb.in_valid) begin
          if (wb.in_is_load) begin
            state_d         = WAIT_LOAD;
            cnt_d           = '0;
            ld_we_d         = wb.in_reg_write;
            ld_reg_d        = wb.in_write_register;
            ld_size_d       = wb.in_load_size;
            ld_signed_d     = wb.in_load_signed;
            ld_off_d        = wb.in_alu_result[1:0];
            load_pending_d  = 1'b1;
            load_register_d = wb.in_reg_write ? wb.in_write_register : 5'd0;
          end else if (wb.in_reg_write && wb.in_write_register != 5'd0) begin
            reg_write_d      = 1'b1;
            write_register_d = wb.in_write_register;
            write_data_d     = wb.in_alu_result;
          end
        end
      end
      default: begin
        cnt_d = cnt_inc;
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (wb.mem_rdata_valid) begin
          state_d         = IDLE;
          load_pending_d  = 1'b0;
          load_register_d = 5'd0;
          if (ld_we_q && ld_reg_q != 5'd0) begin
            reg_write_d      = 1'b1;
            write_register_d = ld_reg_q;
            write_data_d     = load_data;
          end
        end else if (cnt_inc == TIMEOUT_W'(LOAD_TIMEOUT)) begin
          state_d         = IDLE;
          load_pending_d  = 1'b0;
          load_register_d = 5'd0;
          load_timeout_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      ld_we_q          <= 1'b0;
      ld_reg_q         <= 5'd0;
      ld_size_q        <= 2'd0;
      ld_signed_q      <= 1'b0;
      ld_off_q         <= 2'd0;
      reg_write_q      <= 1'b0;
      write_register_q <= 5'd0;
      write_data_q     <= 32'd0;
      load_pending_q   <= 1'b0;
      load_register_q  <= 5'd0;
      load_timeout_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      ld_we_q          <= ld_we_d;
      ld_reg_q         <= ld_reg_d;
      ld_size_q        <= ld_size_d;
      ld_signed_q      <= ld_signed_d;
      ld_off_q         <= ld_off_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      load_pending_q   <= load_pending_d;
      load_register_q  <= load_register_d;
      load_timeout_q   <= load_timeout_d;
    end
  end

  assign wb.in_ready       = (state_q == IDLE);
  assign wb.RegWrite       = reg_write_q;
  assign wb.Write_register = write_register_q;
  assign wb.Write_data     = write_data_q;
  assign wb.load_pending   = load_pending_q;
  assign wb.load_register  = load_register_q;
  assign wb.load_timeout   = load_timeout_q;
endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed bench for mem_writeback_stage: a default-timeout instance tracked by a
// behavioural model every cycle, plus a LOAD_TIMEOUT=3 instance with literal checks.
module tb_mem_writeback_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_writeback_stage_if w1();
  mem_writeback_stage_if w2();

  mem_writeback_stage u1 (.clk(clk), .reset_n(reset_n), .wb(w1.slave));
  mem_writeback_stage #(.LOAD_TIMEOUT(3), .TIMEOUT_W(2)) u2 (.clk(clk), .reset_n(reset_n), .wb(w2.slave));

  assign w2.in_valid          = w1.in_valid;
  assign w2.in_reg_write      = w1.in_reg_write;
  assign w2.in_write_register = w1.in_write_register;
  assign w2.in_alu_result     = w1.in_alu_result;
  assign w2.in_is_load        = w1.in_is_load;
  assign w2.in_load_size      = w1.in_load_size;
  assign w2.in_load_signed    = w1.in_load_signed;
  assign w2.mem_rdata_valid   = w1.mem_rdata_valid;
  assign w2.mem_rdata         = w1.mem_rdata;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a load must write, computed with shifts and signed arithmetic.
  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] off, logic [1:0] sz, bit sgn);
    longint v;
    if (sz == 2'd0) begin
      v = longint'((w >> (8 * off)) & 32'hFF);
      if (sgn && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      v = longint'((w >> (off[1] ? 16 : 0)) & 32'hFFFF);
      if (sgn && v >= 32768) v -= 65536;
    end else v = longint'(w);
    return v[31:0];
  endfunction

  // Model of u1 (LOAD_TIMEOUT=255): busy flag plus count of cycles spent waiting.
  localparam int TO1 = 255;
  bit m_busy, m_we, m_sgn, e_rw, e_pend, e_to;
  int m_wait;
  bit [4:0]  m_reg, e_wr, e_lreg;
  bit [1:0]  m_size, m_off;
  bit [31:0] e_wd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0; m_wait <= 0; m_we <= 0; m_reg <= 0; m_size <= 0; m_off <= 0; m_sgn <= 0;
      e_rw <= 0; e_wr <= 0; e_wd <= 0; e_pend <= 0; e_lreg <= 0; e_to <= 0;
    end else begin
      e_rw <= 0;
      e_to <= 0;
      if (!m_busy) begin
        if (w1.in_valid) begin
          if (w1.in_is_load) begin
            m_busy <= 1; m_wait <= 0;
            m_we <= w1.in_reg_write; m_reg <= w1.in_write_register;
            m_size <= w1.in_load_size; m_off <= w1.in_alu_result[1:0]; m_sgn <= w1.in_load_signed;
            e_pend <= 1;
            e_lreg <= w1.in_reg_write ? w1.in_write_register : 5'd0;
          end else if (w1.in_reg_write && w1.in_write_register != 0) begin
            e_rw <= 1; e_wr <= w1.in_write_register; e_wd <= w1.in_alu_result;
          end
        end
      end else begin
        m_wait <= m_wait + 1;
        if (w1.mem_rdata_valid) begin
          m_busy <= 0; e_pend <= 0; e_lreg <= 0;
          if (m_we && m_reg != 0) begin
            e_rw <= 1; e_wr <= m_reg; e_wd <= ext(w1.mem_rdata, m_off, m_size, m_sgn);
          end
        end else if (m_wait + 1 == TO1) begin
          m_busy <= 0; e_pend <= 0; e_lreg <= 0; e_to <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_in_ready", 32'(w1.in_ready), 32'(!m_busy));
      chk("m_RegWrite", 32'(w1.RegWrite), 32'(e_rw));
      chk("m_Write_register", 32'(w1.Write_register), 32'(e_wr));
      chk("m_Write_data", w1.Write_data, e_wd);
      chk("m_load_pending", 32'(w1.load_pending), 32'(e_pend));
      chk("m_load_register", 32'(w1.load_register), 32'(e_lreg));
      chk("m_load_timeout", 32'(w1.load_timeout), 32'(e_to));
    end
  end

  task automatic cyc(bit v, bit we, logic [4:0] rd, logic [31:0] alu, bit ld,
                     logic [1:0] sz, bit sgn, bit mv, logic [31:0] rdata);
    @(negedge clk);
    w1.in_valid = v; w1.in_reg_write = we; w1.in_write_register = rd;
    w1.in_alu_result = alu; w1.in_is_load = ld; w1.in_load_size = sz;
    w1.in_load_signed = sgn; w1.mem_rdata_valid = mv; w1.mem_rdata = rdata;
  endtask

  task automatic idle();
    cyc(0, 0, 5'd0, 32'd0, 0, 2'd0, 0, 0, 32'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RD = 32'h80F17F01;
  logic [1:0]  t_off [5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
  logic [1:0]  t_sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  bit          t_sgn [5] = '{1, 0, 1, 1, 1};
  logic [31:0] t_exp [5] = '{32'hFFFFFFF1, 32'h00000080, 32'h00007F01, 32'hFFFF80F1, 32'h80F17F01};
  int to_pulses, rw_seen;

  initial begin
    w1.in_valid = 0; w1.in_reg_write = 0; w1.in_write_register = 0; w1.in_alu_result = 0;
    w1.in_is_load = 0; w1.in_load_size = 0; w1.in_load_signed = 0;
    w1.mem_rdata_valid = 0; w1.mem_rdata = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    settle();
    chk("rst_in_ready", 32'(w1.in_ready), 32'd1);
    chk("rst_outputs", {w1.RegWrite, w1.Write_register, w1.load_pending, w1.load_register, w1.load_timeout}, 32'd0);
    chk("rst_Write_data", w1.Write_data, 32'd0);

    // ALU back-to-back
    cyc(1, 1, 5'd5, 32'h12345678, 0, 2'd0, 0, 0, 32'd0); settle();
    chk("alu1", {w1.RegWrite, w1.in_ready, w1.Write_register}, {25'd0, 1'b1, 1'b1, 5'd5});
    chk("alu1_data", w1.Write_data, 32'h12345678);
    cyc(1, 1, 5'd6, 32'hDEADBEEF, 0, 2'd0, 0, 0, 32'd0); settle();
    chk("alu2", {w1.RegWrite, w1.in_ready, w1.Write_register}, {25'd0, 1'b1, 1'b1, 5'd6});
    chk("alu2_data", w1.Write_data, 32'hDEADBEEF);
    // r0 and reg_write=0 never write; port holds previous value
    cyc(1, 1, 5'd0, 32'h11111111, 0, 2'd0, 0, 0, 32'd0); settle();
    chk("r0_nowrite", {w1.RegWrite, w1.Write_register}, {26'd0, 5'd6});
    cyc(1, 0, 5'd7, 32'h22222222, 0, 2'd0, 0, 0, 32'd0); settle();
    chk("nowe_nowrite", 32'(w1.RegWrite), 32'd0);
    chk("hold_data", w1.Write_data, 32'hDEADBEEF);

    // Byte/half/word extraction, data valid in first wait cycle
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 5'(10 + i), {30'h100, t_off[i]}, 1, t_sz[i], t_sgn[i], 0, 32'd0); settle();
      chk("ext_pending", {w1.load_pending, w1.load_register}, {26'd0, 1'b1, 5'(10 + i)});
      cyc(0, 0, 5'd0, 32'd0, 0, 2'd0, 0, 1, RD); settle();
      chk("ext_rw", {w1.RegWrite, w1.Write_register}, {26'd0, 1'b1, 5'(10 + i)});
      chk("ext_data", w1.Write_data, t_exp[i]);
    end

    // LW r9, data valid 4 wait cycles later, accept in write cycle
    cyc(1, 1, 5'd9, 32'h200, 1, 2'd2, 0, 0, 32'd0); settle();
    for (int i = 0; i < 4; i++) begin
      chk("wait_state", {w1.in_ready, w1.load_pending, w1.load_register, w1.RegWrite}, {24'd0, 1'b0, 1'b1, 5'd9, 1'b0});
      if (i < 3) begin idle(); settle(); end
    end
    cyc(0, 0, 5'd0, 32'd0, 0, 2'd0, 0, 1, 32'hCAFEF00D); settle();
    chk("wait_write", {w1.RegWrite, w1.in_ready, w1.load_pending, w1.Write_register}, {24'd0, 3'b110, 5'd9});
    chk("wait_data", w1.Write_data, 32'hCAFEF00D);
    cyc(1, 1, 5'd11, 32'h55, 0, 2'd0, 0, 0, 32'd0); settle();
    chk("accept_in_write", {w1.RegWrite, w1.Write_register, w1.Write_data[7:0]}, {18'd0, 1'b1, 5'd11, 8'h55});

    // Timeout on the LOAD_TIMEOUT=3 instance
    @(negedge clk); reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    cyc(1, 1, 5'd12, 32'h300, 1, 2'd2, 0, 0, 32'd0); settle();
    for (int i = 0; i < 2; i++) begin
      chk("to_wait", {w2.load_pending, w2.load_timeout, w2.in_ready}, 32'b100);
      idle(); settle();
    end
    chk("to_last_wait", {w2.load_pending, w2.load_timeout}, 32'b10);
    idle(); settle();
    chk("to_pulse", {w2.load_timeout, w2.RegWrite, w2.load_pending, w2.in_ready}, 32'b1001);
    idle(); settle();
    chk("to_pulse_end", {w2.load_timeout, w2.RegWrite}, 32'b00);

    // Data in the cycle the counter reaches 3 beats the timeout (u1 completes r12 here)
    cyc(1, 1, 5'd13, 32'h301, 1, 2'd0, 0, 0, 32'd0); settle();
    idle(); settle();
    idle(); settle();
    cyc(0, 0, 5'd0, 32'd0, 0, 2'd0, 0, 1, RD); settle();
    chk("data_wins", {w2.RegWrite, w2.load_timeout, w2.Write_register}, {25'd0, 2'b10, 5'd13});
    chk("data_wins_val", w2.Write_data, 32'h0000007F);

    // Reset in WAIT_LOAD, then late data: nothing written
    cyc(1, 1, 5'd14, 32'h400, 1, 2'd2, 0, 0, 32'd0); settle();
    chk("pre_reset_pending", {w1.load_pending, w1.load_register}, {26'd0, 1'b1, 5'd14});
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", {w1.RegWrite, w1.Write_register, w1.load_pending, w1.load_register, w1.load_timeout, w1.in_ready}, 32'd1);
    chk("async_reset_data", w1.Write_data, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    cyc(0, 0, 5'd0, 32'd0, 0, 2'd0, 0, 1, 32'hFFFFFFFF); settle();
    chk("late_rdata", {w1.RegWrite, w2.RegWrite, w1.Write_register}, 32'd0);

    // Full-length timeout on the default instance
    cyc(1, 1, 5'd15, 32'h500, 1, 2'd2, 0, 0, 32'd0); settle();
    to_pulses = 0; rw_seen = 0;
    for (int i = 0; i < 260; i++) begin
      idle(); settle();
      if (w1.load_timeout) to_pulses++;
      if (w1.RegWrite) rw_seen++;
      if (i == 253) chk("to255_before", {w1.load_pending, w1.load_timeout}, 32'b10);
      if (i == 254) chk("to255_pulse", {w1.load_pending, w1.load_timeout}, 32'b01);
    end
    chk("to255_count", 32'(to_pulses), 32'd1);
    chk("to255_nowrite", 32'(rw_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
